// File: rtl/axis_fifo.sv
// Synchronous AXI-Stream FIFO with first-word fall-through output, carrying keep/last per beat
// and reporting both stored beats and complete packets held.
module axis_fifo #(
   parameter int unsigned WORD_W = 8,
   parameter int unsigned BUS_W  = 32,
   parameter int unsigned DEPTH  = 16,
   localparam int unsigned WORDS_PER_BEAT = BUS_W / WORD_W,
   localparam int unsigned CNT_W          = $clog2(DEPTH) + 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               s_valid,
   output logic                               s_ready,
   input  logic [WORDS_PER_BEAT*WORD_W-1:0]   s_data,
   input  logic [WORDS_PER_BEAT-1:0]          s_keep,
   input  logic                               s_last,
   output logic                               m_valid,
   input  logic                               m_ready,
   output logic [WORDS_PER_BEAT*WORD_W-1:0]   m_data,
   output logic [WORDS_PER_BEAT-1:0]          m_keep,
   output logic                               m_last,
   output logic [CNT_W-1:0]                   count,
   output logic [CNT_W-1:0]                   pkt_count
);

   localparam int unsigned AddrW = $clog2(DEPTH);
   localparam int unsigned DataW = WORDS_PER_BEAT * WORD_W;
   localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

   logic [DataW-1:0]          data_mem [DEPTH];
   logic [WORDS_PER_BEAT-1:0] keep_mem [DEPTH];
   logic [DEPTH-1:0]          last_mem;

   logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
   logic             push, pop;
   logic             pkt_inc, pkt_dec;

   // Handshakes derive only from registered occupancy, so a full FIFO refuses even while popping.
   always_comb begin
      s_ready     = (count_q != FullCnt) && !rst;
      m_valid     = (count_q != '0);
      push        = s_valid && s_ready;
      pop         = m_valid && m_ready;
      pkt_inc     = push && s_last;
      pkt_dec     = pop && m_last;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      pkt_count_d = pkt_count_q;
      if (push) wr_ptr_d = wr_ptr_q + AddrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AddrW'(1);
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
      if (pkt_inc && !pkt_dec) begin
         pkt_count_d = pkt_count_q + CNT_W'(1);
      end else if (pkt_dec && !pkt_inc) begin
         pkt_count_d = pkt_count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         pkt_count_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         pkt_count_q <= pkt_count_d;
      end
   end

   // Storage is never reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr_q] <= s_data;
         keep_mem[wr_ptr_q] <= s_keep;
         last_mem[wr_ptr_q] <= s_last;
      end
   end

   assign m_data    = data_mem[rd_ptr_q];
   assign m_keep    = keep_mem[rd_ptr_q];
   assign m_last    = last_mem[rd_ptr_q];
   assign count     = count_q;
   assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_axis_fifo.sv
// Scoreboard bench for axis_fifo: drivers queue accepted beats, a negedge monitor checks pops,
// stability under backpressure and an occupancy model every cycle.
module tb_axis_fifo;

   localparam int unsigned Depth     = 16;
   localparam int unsigned ProbValid = 70;
   localparam int unsigned ProbReady = 60;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } beat_t;

   logic        clk, rst;
   logic        s_valid, s_ready, s_last;
   logic [31:0] s_data;
   logic [3:0]  s_keep;
   logic        m_valid, m_ready, m_last;
   logic [31:0] m_data;
   logic [3:0]  m_keep;
   logic [4:0]  count, pkt_count;

   logic        m_ready_dir, rand_rdy;
   beat_t       expq[$];
   int          tests, fails;

   axis_fifo #(.WORD_W(8), .BUS_W(32), .DEPTH(Depth)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_keep    (s_keep),
      .s_last    (s_last),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_keep    (m_keep),
      .m_last    (m_last),
      .count     (count),
      .pkt_count (pkt_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // m_ready is either directed or randomly stalled; updated after the driver's #1 slot.
   initial m_ready = 1'b0;
   always @(posedge clk) begin
      #2;
      m_ready = rand_rdy ? ($urandom_range(0, 99) < ProbReady) : m_ready_dir;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: model occupancy, compare popped beats with the scoreboard, check hold stability.
   int    mdl_cnt, mdl_pkt;
   logic  hold_v;
   beat_t held, cur;
   logic  mon_push, mon_pop, pop_last;

   always @(negedge clk) begin
      if (rst) begin
         mdl_cnt = 0;
         mdl_pkt = 0;
         hold_v  = 1'b0;
      end else begin
         chk("count", 64'(count), 64'(mdl_cnt));
         chk("pkt_count", 64'(pkt_count), 64'(mdl_pkt));
         chk("m_valid", 64'(m_valid), 64'(mdl_cnt != 0));
         chk("s_ready", 64'(s_ready), 64'(mdl_cnt != int'(Depth)));
         cur      = {m_data, m_keep, m_last};
         mon_push = s_valid && s_ready;
         mon_pop  = m_valid && m_ready;
         pop_last = 1'b0;
         if (hold_v && m_valid) chk("m_hold", 64'(cur), 64'(held));
         hold_v = m_valid && !m_ready;
         held   = cur;
         if (mon_pop) begin
            if (expq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL m_beat: got unexpected beat %0h, expected none at %0t", cur, $time);
            end else begin
               chk("m_beat", 64'(cur), 64'(expq[0]));
               pop_last = expq[0].l;
               void'(expq.pop_front());
            end
         end
         mdl_cnt = mdl_cnt + int'(mon_push) - int'(mon_pop);
         mdl_pkt = mdl_pkt + int'(mon_push && s_last) - int'(mon_pop && pop_last);
      end
   end

   // Called at posedge+1; returns at posedge+1 after the beat's push edge, s_valid left high.
   task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      bit done;
      done    = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      s_keep  = k;
      s_last  = l;
      for (int c = 0; c < 500 && !done; c++) begin
         @(negedge clk);
         if (s_ready) begin
            expq.push_back('{d: d, k: k, l: l});
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: got no s_ready, expected acceptance at %0t", $time);
      end
   endtask

   task automatic idle_gaps();
      while ($urandom_range(0, 99) >= ProbValid) begin
         s_valid = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      bit empty;
      empty       = 1'b0;
      s_valid     = 1'b0;
      rand_rdy    = 1'b0;
      m_ready_dir = 1'b1;
      for (int c = 0; c < 500 && !empty; c++) begin
         @(negedge clk);
         empty = (expq.size() == 0);
      end
      chk("drain_done", 64'(empty), 64'(1));
      chk("drain_count", 64'(count), 64'(0));
      chk("drain_pkt", 64'(pkt_count), 64'(0));
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests       = 0;
      fails       = 0;
      rst         = 1'b1;
      s_valid     = 1'b0;
      s_data      = '0;
      s_keep      = '0;
      s_last      = 1'b0;
      m_ready_dir = 1'b0;
      rand_rdy    = 1'b0;

      // Reset state and first cycle after release
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 64'(count), 64'(0));
      chk("rst_pkt", 64'(pkt_count), 64'(0));
      chk("rst_m_valid", 64'(m_valid), 64'(0));
      chk("rst_s_ready", 64'(s_ready), 64'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_s_ready", 64'(s_ready), 64'(1));
      @(posedge clk);
      #1;

      // Single beat, no same-cycle bypass, latency one cycle
      m_ready_dir = 1'b1;
      s_valid     = 1'b1;
      s_data      = 32'h0403_0201;
      s_keep      = 4'hF;
      s_last      = 1'b1;
      @(negedge clk);
      chk("no_bypass", 64'(m_valid), 64'(0));
      chk("single_s_ready", 64'(s_ready), 64'(1));
      expq.push_back('{d: 32'h0403_0201, k: 4'hF, l: 1'b1});
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      @(negedge clk);
      chk("single_m_valid", 64'(m_valid), 64'(1));
      chk("single_count1", 64'(count), 64'(1));
      chk("single_pkt1", 64'(pkt_count), 64'(1));
      @(negedge clk);
      chk("single_count0", 64'(count), 64'(0));
      chk("single_pkt0", 64'(pkt_count), 64'(0));
      @(posedge clk);
      #1;

      // Fill to 16, 17th held by source, then pop while full
      m_ready_dir = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 16; i++) send_beat(32'hA000_0000 + i, 4'hF, (i % 4) == 3);
      s_valid = 1'b1;
      s_data  = 32'hB000_0017;
      s_keep  = 4'hF;
      s_last  = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("full_count", 64'(count), 64'(16));
         chk("full_s_ready", 64'(s_ready), 64'(0));
         chk("full_pkt", 64'(pkt_count), 64'(4));
         @(posedge clk);
         #1;
      end
      m_ready_dir = 1'b1;
      @(negedge clk);
      chk("full_pop_s_ready", 64'(s_ready), 64'(0));
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("after_pop_count", 64'(count), 64'(15));
      chk("after_pop_s_ready", 64'(s_ready), 64'(1));
      expq.push_back('{d: 32'hB000_0017, k: 4'hF, l: 1'b1});
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      @(negedge clk);
      chk("push_pop_count", 64'(count), 64'(15));
      @(posedge clk);
      #1;
      drain();

      // Wrap: one 40-beat packet with random stalls on both sides
      rand_rdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         idle_gaps();
         send_beat($urandom, 4'($urandom_range(1, 15)), i == 39);
      end
      drain();

      // Reset mid-packet discards stored beats
      m_ready_dir = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) send_beat(32'hC000_0000 + i, 4'hF, 1'b0);
      s_valid = 1'b0;
      rst     = 1'b1;
      #1;
      chk("mid_rst_count", 64'(count), 64'(0));
      chk("mid_rst_pkt", 64'(pkt_count), 64'(0));
      chk("mid_rst_m_valid", 64'(m_valid), 64'(0));
      chk("mid_rst_s_ready", 64'(s_ready), 64'(0));
      expq.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_release_s_ready", 64'(s_ready), 64'(1));
      chk("mid_rst_release_m_valid", 64'(m_valid), 64'(0));
      @(posedge clk);
      #1;
      m_ready_dir = 1'b1;
      for (int i = 0; i < 3; i++) send_beat(32'hD000_0000 + i, 4'hF, i == 2);
      drain();

      // Packet regression: 20 packets of 1..100 beats, partial keep on final beat
      rand_rdy = 1'b1;
      for (int p = 0; p < 20; p++) begin
         int n;
         n = $urandom_range(1, 100);
         for (int b = 0; b < n; b++) begin
            idle_gaps();
            if (b == n - 1) send_beat($urandom, 4'((1 << $urandom_range(1, 3)) - 1), 1'b1);
            else            send_beat($urandom, 4'hF, 1'b0);
         end
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
